// File: rtl/spi_target_regs.sv
// SPI target that exposes a 16 x 8 register file. SCLK, MOSI and nCS are oversampled in clk.
// Command byte: bit 7 = read, bits [3:0] = start address. Data bytes auto-increment the address, wrapping mod 16.
module spi_target_regs #(
  parameter logic [7:0] DEV_ID      = 8'h5A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       spi_ncs,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_s, mosi_s, ncs_s;
  logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge, ncs_fall, ncs_rise;
  logic [1:0]             mode_q, mode_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             in_sr_q, in_sr_d, out_sr_q, out_sr_d;
  logic [3:0]             addr_q, addr_d, addr_inc;
  logic                   oe_q, oe_d, done_q, done_d, wr_en;
  logic [7:0]             regs_q [16];
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   wr_strobe_q;
  logic [3:0]             wr_addr_q;
  logic [7:0]             wr_data_q;

  // The nCS chain resets low so that a select already held low at reset release is not seen as a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi_ncs};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = ~sclk_prev_q & sclk_s;
  assign sclk_fall   = sclk_prev_q & ~sclk_s;
  assign ncs_fall    = ncs_prev_q & ~ncs_s;
  assign ncs_rise    = ~ncs_prev_q & ncs_s;
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;
  assign addr_inc    = addr_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    in_sr_d   = in_sr_q;
    out_sr_d  = out_sr_q;
    addr_d    = addr_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    wr_en     = 1'b0;
    if (state_q == IDLE) begin
      if (ncs_fall) begin
        state_d   = CMD;
        mode_d    = mode;
        bit_cnt_d = 3'd0;
        out_sr_d  = DEV_ID;
        oe_d      = 1'b1;
      end
    end else if (ncs_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      if (sample_edge) begin
        in_sr_d   = {in_sr_q[6:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        done_d    = (bit_cnt_q == 3'd7);
      end
      // bit_cnt == 0 marks the edge just before or after a byte boundary, where the reload already supplies the MSB.
      if (shift_edge && (bit_cnt_q != 3'd0)) out_sr_d = {out_sr_q[6:0], 1'b0};
      if (done_q) begin
        case (state_q)
          CMD: begin
            addr_d = in_sr_q[3:0];
            if (in_sr_q[7]) begin
              state_d  = RDATA;
              out_sr_d = regs_q[in_sr_q[3:0]];
            end else begin
              state_d  = WDATA;
              out_sr_d = 8'h00;
            end
          end
          WDATA: begin
            wr_en    = 1'b1;
            addr_d   = addr_inc;
            out_sr_d = 8'h00;
          end
          default: begin
            addr_d   = addr_inc;
            out_sr_d = regs_q[addr_inc];
          end
        endcase
      end
    end
  end

  // A write that lands on rd_addr is forwarded so that rd_data and the register update together.
  always_comb begin
    rd_data_d = regs_q[rd_addr];
    if (wr_en && (addr_q == rd_addr)) rd_data_d = in_sr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 2'd0;
      bit_cnt_q   <= 3'd0;
      in_sr_q     <= 8'h00;
      out_sr_q    <= 8'h00;
      addr_q      <= 4'd0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'h00;
      rd_data_q   <= 8'h00;
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      in_sr_q     <= in_sr_d;
      out_sr_q    <= out_sr_d;
      addr_q      <= addr_d;
      oe_q        <= oe_d;
      done_q      <= done_d;
      wr_strobe_q <= wr_en;
      rd_data_q   <= rd_data_d;
      if (wr_en) begin
        regs_q[addr_q] <= in_sr_q;
        wr_addr_q      <= addr_q;
        wr_data_q      <= in_sr_q;
      end
    end
  end

  assign spi_miso    = oe_q & out_sr_q[7];
  assign spi_miso_oe = oe_q;
  assign rd_data     = rd_data_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: doc/spi_target_regs.md
Name: spi_target_regs

Overview:
- SPI target (responder) for the UART-to-SPI programmer: a 16 x 8 register file that an SPI initiator can read and write.
- Lets the programming link be tested in a loopback, and gives FPGA-side logic a configuration block that is loaded over SPI.
- SCLK, MOSI and nCS are oversampled in the clk domain; all logic is synchronous to clk.

Parameters:
- DEV_ID, 8'h5A: byte shifted out on MISO during the command byte.
- SYNC_STAGES, 2: synchronizer depth on spi_sclk, spi_mosi and spi_ncs (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  {CPOL,CPHA}; sampled only while nCS is high.
- spi_ncs  in  1  chip select, active low.
- spi_sclk  in  1  SPI clock from the initiator.
- spi_mosi  in  1  initiator-to-target data, MSB first.
- spi_miso  out  1  target-to-initiator data, MSB first.
- spi_miso_oe  out  1  high while selected; drives an external tristate.
- rd_addr  in  4  local read address.
- rd_data  out  8  reg[rd_addr], registered (1-cycle latency).
- wr_strobe  out  1  1-cycle pulse when SPI commits a register write.
- wr_addr  out  4  address of the committed write.
- wr_data  out  8  data of the committed write.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all 16 registers = 8'h00;
  - spi_miso = 0, spi_miso_oe = 0, rd_data = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0;
  - FSM in IDLE.
- Timing constraints on the initiator:
  - SCLK high and low phases each >= 4 clk;
  - nCS fall to first SCLK edge >= 4 clk;
  - last SCLK edge to nCS rise >= 4 clk.
- Edge detection: on the synchronized SCLK.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge is leading when CPHA=0, trailing when CPHA=1. The other edge is the shift edge.
- mode is latched on the synchronized nCS falling edge.
- FSM states: IDLE, CMD, WDATA, RDATA.
  - IDLE -> CMD on synchronized nCS fall: bit_cnt = 0; out_sr = DEV_ID; spi_miso_oe = 1.
  - A synchronized nCS rise in any state -> IDLE: partial byte discarded, no write, spi_miso_oe = 0 and spi_miso = 0 on the following clk.
- Per byte:
  - mosi is shifted into in_sr on each sample edge; bit_cnt is 3 bits and wraps 7 -> 0.
  - byte_done = the sample edge with bit_cnt == 7.
- spi_miso = out_sr[7] while selected.
  - CPHA=0: out_sr shifts left on the trailing edges of bits 0..6. The trailing edge after bit 7 does not shift, because a reload has already occurred.
  - CPHA=1: out_sr shifts left on the leading edges of bits 1..7. The leading edge of bit 0 does not shift.
  - Reload of out_sr happens on the clk after byte_done.
- CMD byte_done:
  - addr = in_sr[3:0]; in_sr[6:4] ignored.
  - in_sr[7] = 1: go to RDATA, out_sr = reg[addr].
  - in_sr[7] = 0: go to WDATA, out_sr = 8'h00.
- WDATA byte_done:
  - reg[addr] = byte; wr_strobe = 1 for 1 clk with wr_addr/wr_data;
  - addr = addr + 1 mod 16; out_sr = 8'h00.
- RDATA byte_done:
  - addr = addr + 1 mod 16; out_sr = reg[new addr].
  - Bytes received on MOSI are ignored.
- Address wrap: 4'hF -> 4'h0, in both read and write.
- Local port: rd_data <= reg[rd_addr] every clk.
  - If a write commits to rd_addr in the same clk, rd_data shows the new value one clk after the write commits (write-first).
- Reset asserted mid-transaction: immediate IDLE.
  - After release, the target ignores SCLK until the next synchronized nCS fall; a low nCS at release does not start a transaction.

Test Plan:
- Reset, mode 0: nCS low, send 8'h03, 8'hC3, 8'h7E -> MISO returns 8'h5A, 8'h00, 8'h00; wr_strobe pulses twice (addr 3 data C3, addr 4 data 7E); rd_addr=4 -> rd_data=8'h7E one clk later.
- Mode 3, read: after the previous writes send 8'h83, 8'h00, 8'h00 -> MISO 8'h5A, 8'hC3, 8'h7E; no wr_strobe.
- Modes 1 and 2: repeat the write/read of 8'hA5 at addr F, then continue one more byte -> the second byte goes to addr 0 (wrap); the read returns A5 then reg[0].
- Abort: nCS rises after 5 bits of a WDATA byte -> no wr_strobe, register unchanged; the next transaction starts cleanly with MISO = 8'h5A.
- rst_n pulsed low mid-RDATA -> spi_miso_oe = 0 immediately, all registers read 8'h00, and no activity until a new nCS fall.
- Minimum timing: SCLK phases of exactly 4 clk, nCS-to-SCLK gaps of exactly 4 clk, all 4 modes, with a random-data scoreboard over 16-byte bursts -> zero mismatches.
